// File: rtl/peach_dmem_responder_if.sv
// Core <-> data-memory request/response bundle for peach_dmem_responder.
// The core side uses the master modport and the responder uses the slave modport.
interface peach_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/peach_dmem_responder.sv
// Single-outstanding RV32I data-memory responder with programmable wait states.
// Define PEACH_DMEM_MISALIGN_ERR_EN to reject misaligned halfword/word accesses.
module peach_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic                   clk,
    input logic                   reset,
    peach_dmem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             acc_err;
    logic [3:0]       lane_mask;
    logic [31:0]      bit_mask;
    logic [31:0]      rd_word;
    logic [31:0]      st_data;
    logic [31:0]      wr_word;
    logic [31:0]      ld_data;

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return !(f3 inside {3'b000, 3'b001, 3'b010});
        return f3 inside {3'b011, 3'b110, 3'b111};
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b010:  return word;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return '0;
        endcase
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'b000:  return 4'b0001 << lane;
            3'b001:  return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Access stage: address decode, legality, and read-modify-write word
    always_comb begin
        off = addr_q[1:0];
        case (funct3_q[1:0])
            2'b01:   off = {addr_q[1], 1'b0};
            2'b10:   off = 2'b00;
            default: off = addr_q[1:0];
        endcase
        idx     = addr_q[IDX_W+1:2];
        rd_word = mem[idx];
        acc_err = funct3_illegal(we_q, funct3_q) ||
                  ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
`ifdef PEACH_DMEM_MISALIGN_ERR_EN
        if ((funct3_q[1:0] == 2'b01 && addr_q[0]) ||
            (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00))
            acc_err = 1'b1;
`endif
        lane_mask = store_lanes(funct3_q, off);
        for (int i = 0; i < 4; i++)
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        case (funct3_q)
            3'b000:  st_data = {4{wdata_q[7:0]}};
            3'b001:  st_data = {2{wdata_q[15:0]}};
            default: st_data = wdata_q;
        endcase
        wr_word = (rd_word & ~bit_mask) | (st_data & bit_mask);
        ld_data = load_extract(rd_word, funct3_q, off);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1)
                        state <= ACCESS;
                end
                ACCESS: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= acc_err;
                    rsp_rdata_q <= (acc_err || we_q) ? 32'd0 : ld_data;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture; data path is not reset
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            we_q     <= bus.req_we;
            addr_q   <= bus.req_addr;
            funct3_q <= bus.req_funct3;
            wdata_q  <= bus.req_wdata;
        end
    end

    // An async reset forces state out of ACCESS, so an aborted store never lands
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && !acc_err)
            mem[idx] <= wr_word;
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/peach_dmem_responder.md
PEACH_DMEM_RESPONDER -- requirements
Module: peach_dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024, number of 32-bit words in the data array.
REQ-002 Parameter: WAIT_CYCLES, default 1, wait cycles inserted between request accept and array access (0..15).
REQ-003 Port: clk  input  1  clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  1  core request present.
REQ-006 Port: req_ready  output  1  responder can accept a request.
REQ-007 Port: req_we  input  1  1 = store, 0 = load.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_funct3  input  3  RV32I load/store funct3 (size/sign).
REQ-010 Port: req_wdata  input  32  store data, right-aligned.
REQ-011 Port: rsp_valid  output  1  response present.
REQ-012 Port: rsp_ready  input  1  core accepts response.
REQ-013 Port: rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 Port: rsp_err  output  1  request rejected; no array write occurred.

Function
REQ-015 FSM states: IDLE, WAIT, ACCESS, RESP; req_ready SHALL equal (state==IDLE), combinationally.
REQ-016 IDLE: on req_valid high, latch we/addr/funct3/wdata and go to WAIT with counter=WAIT_CYCLES, or to ACCESS if WAIT_CYCLES==0.
REQ-017 WAIT: decrement counter each cycle; exactly WAIT_CYCLES cycles spent in WAIT, then ACCESS.
REQ-018 ACCESS: exactly one cycle; store commits to array and rsp_rdata/rsp_err are registered at the edge leaving ACCESS; next state RESP.
REQ-019 RESP: rsp_valid high, rsp_rdata/rsp_err held stable until rsp_ready high; on that edge go to IDLE with rsp_valid low.
REQ-020 Latency: rsp_valid first high WAIT_CYCLES+2 cycles after the accept cycle (default 3); back-to-back throughput one request per WAIT_CYCLES+3 cycles minimum.
REQ-021 Request inputs outside IDLE SHALL be ignored; only one outstanding request.
REQ-022 Word index = addr[31:2]; index >= DEPTH_WORDS -> rsp_err=1, no write, rsp_rdata=0.
REQ-023 Illegal funct3 (load: 011,110,111; store: anything other than 000/001/010) -> rsp_err=1, no write, rsp_rdata=0.
REQ-024 Stores: SB (000) writes wdata[7:0] to byte lane addr[1:0]; SH (001) writes wdata[15:0] to lanes {addr[1],0}/{addr[1],1}; SW (010) writes all four lanes; unwritten lanes unchanged; little-endian.
REQ-025 Loads: LB/LBU select byte lane addr[1:0], LH/LHU select halfword addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW returns full word.
REQ-026 Store response: rsp_rdata=0, rsp_err=0 when legal.

Reset
REQ-027 During and after reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-028 Reset in WAIT or ACCESS SHALL abort the request; a store not yet past the ACCESS exit edge SHALL NOT modify the array.
REQ-029 Array contents SHALL NOT be cleared by reset; simulation initial value all zeros.

Configuration
REQ-030 Macro PEACH_DMEM_MISALIGN_ERR_EN defined: halfword access with addr[0]=1 or word access with addr[1:0]!=0 -> rsp_err=1, no write, rsp_rdata=0.
REQ-031 Macro undefined: no misalignment error; halfword accesses treat addr[0] as 0, word accesses treat addr[1:0] as 0.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_err=0, rsp_rdata=0xDEADBEEF; rsp_valid rises 3 cycles after each accept (WAIT_CYCLES=1).
REQ-033 After REQ-032, SB 0x5A @0x12 then LW @0x10 -> 0xDE5ABEEF; LB @0x12 -> 0x0000005A; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDE5A.
REQ-034 LW @0x1000 with DEPTH_WORDS=1024 -> rsp_err=1, rsp_rdata=0; SW @0x1000 -> rsp_err=1, word 0 unchanged.
REQ-035 Hold rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, new req_valid ignored; raise rsp_ready -> IDLE next cycle.
REQ-036 SW 0x11111111 @0x20, assert reset during WAIT, then LW @0x20 -> previous value (0) returned; rsp_valid low immediately on reset.
REQ-037 LW @0x22: with PEACH_DMEM_MISALIGN_ERR_EN -> rsp_err=1, rsp_rdata=0; without -> rsp_err=0, data of word @0x20.
